// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryptor: one cipher round per clock, round keys
// derived on the fly. Ports: CLK, RESET (async low), AES_START/AES_DONE
// handshake, AES_KEY, AES_MSG_PLAIN in, AES_MSG_ENC out.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Forward S-box, byte 0x00 in the top bits.
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = 11'd2047 - {a, 3'b000};
  assign y   = TBL[idx -: 8];
endmodule

module aes_encrypt_core #(
  parameter int unsigned NR = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  output logic         AES_DONE,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_PLAIN,
  output logic [127:0] AES_MSG_ENC
);
  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  localparam logic [3:0] LAST = 4'(NR - 1);

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] st;
  logic [127:0] rk;

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] nrk;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  tw;
  logic [7:0]   rcon;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the column-major state rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    shift_rows = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [7:0] a0, a1, a2, a3;
    mix_cols = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      mix_cols[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mix_cols[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mix_cols[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mix_cols[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sbs
    aes_sbox u_sbox (
      .a (st[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  assign rot = {rk[23:0], rk[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sbk
    aes_sbox u_sbox (
      .a (rot[31-8*j -: 8]),
      .y (sub[31-8*j -: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    unique case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Next round key: each word chains off the freshly produced one.
  assign tw            = sub ^ {rcon, 24'h0};
  assign nrk[127:96]   = rk[127:96] ^ tw;
  assign nrk[95:64]    = rk[95:64] ^ nrk[127:96];
  assign nrk[63:32]    = rk[63:32] ^ nrk[95:64];
  assign nrk[31:0]     = rk[31:0] ^ nrk[63:32];

  assign sr = shift_rows(sb);
  assign mc = mix_cols(sr);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fsm         <= IDLE;
      round       <= '0;
      st          <= '0;
      rk          <= '0;
      AES_MSG_ENC <= '0;
      AES_DONE    <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (AES_START) begin
            st    <= AES_MSG_PLAIN ^ AES_KEY;
            rk    <= AES_KEY;
            round <= 4'd1;
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          st    <= mc ^ nrk;
          rk    <= nrk;
          round <= round + 4'd1;
          if (round == LAST) fsm <= FINAL;
        end
        FINAL: begin
          st          <= sr ^ nrk;
          rk          <= nrk;
          AES_MSG_ENC <= sr ^ nrk;
          AES_DONE    <= 1'b1;
          round       <= '0;
          fsm         <= DONE;
        end
        DONE: begin
          if (!AES_START) begin
            AES_DONE <= 1'b0;
            fsm      <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: FIPS vectors, handshake, reset abort,
// input stability and random vectors against a byte-level AES model.

module tb_aes_encrypt_core;
  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         AES_START = 1'b0;
  logic         AES_DONE;
  logic [127:0] AES_KEY = '0;
  logic [127:0] AES_MSG_PLAIN = '0;
  logic [127:0] AES_MSG_ENC;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] inv_m [256];
  logic [7:0] ks [176];

  always #5 CLK = ~CLK;

  aes_encrypt_core dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AES_START     (AES_START),
    .AES_DONE      (AES_DONE),
    .AES_KEY       (AES_KEY),
    .AES_MSG_PLAIN (AES_MSG_PLAIN),
    .AES_MSG_ENC   (AES_MSG_ENC)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: GF inverse then affine map.
  function automatic void build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
          ^ rotl(inv, 4) ^ 8'h63;
      sbox_m[x] = s;
      inv_m[s] = 8'(x);
    end
  endfunction

  function automatic void expand_key(input logic [127:0] key);
    logic [7:0] t0, t1, t2, t3, u, rc;
    for (int i = 0; i < 16; i++) ks[i] = key[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      t0 = ks[i-4]; t1 = ks[i-3]; t2 = ks[i-2]; t3 = ks[i-1];
      if (i % 16 == 0) begin
        u  = t0;
        t0 = sbox_m[t1] ^ rc;
        t1 = sbox_m[t2];
        t2 = sbox_m[t3];
        t3 = sbox_m[u];
        rc = gmul(rc, 8'h02);
      end
      ks[i]   = ks[i-16] ^ t0;
      ks[i+1] = ks[i-15] ^ t1;
      ks[i+2] = ks[i-14] ^ t2;
      ks[i+3] = ks[i-13] ^ t3;
    end
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] key,
                                           input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] o;
    expand_key(key);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[i];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = sbox_m[s[4*((c+w)%4)+w]];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
          for (int i = 0; i < 4; i++)
            s[4*c+i] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03)
                       ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[16*r+i];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] key,
                                           input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] o;
    expand_key(key);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks[160+i];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*((c+w)%4)+w] = inv_m[s[4*c+w]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ ks[16*r+i];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
          for (int i = 0; i < 4; i++)
            s[4*c+i] = gmul(a[i], 8'h0e) ^ gmul(a[(i+1)%4], 8'h0b)
                       ^ gmul(a[(i+2)%4], 8'h0d)
                       ^ gmul(a[(i+3)%4], 8'h09);
        end
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Returns #1 after the edge that samples the inputs.
  task automatic start_enc(input logic [127:0] k, input logic [127:0] p);
    @(posedge CLK); #1;
    AES_KEY = k;
    AES_MSG_PLAIN = p;
    AES_START = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!AES_DONE && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag,
                         input logic [127:0] k,
                         input logic [127:0] p);
    int lat;
    start_enc(k, p);
    wait_done(lat);
    check({tag, "_lat"}, 128'(lat), 128'd10);
    check({tag, "_ct"}, AES_MSG_ENC, ref_enc(k, p));
  endtask

  task automatic release_start(input string tag);
    AES_START = 1'b0;
    @(posedge CLK); #1;
    check({tag, "_done_fall"}, 128'(AES_DONE), 128'd0);
  endtask

  initial begin
    logic [127:0] k, p, ct;
    int lat, hi;
    build_sbox();

    #3;
    check("rst_done", 128'(AES_DONE), 128'd0);
    check("rst_enc", AES_MSG_ENC, 128'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    p = 128'h3243f6a8885a308d313198a2e0370734;
    run_vec("fips_b", k, p);
    check("fips_b_const", AES_MSG_ENC,
          128'h3925841d02dc09fbdc118597196a0b32);
    release_start("fips_b");

    k = 128'h000102030405060708090a0b0c0d0e0f;
    p = 128'h00112233445566778899aabbccddeeff;
    run_vec("fips_c1", k, p);
    check("fips_c1_const", AES_MSG_ENC,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Hold AES_START high long after completion.
    ct = AES_MSG_ENC;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (AES_DONE) hi++;
      if (i == 10) begin
        AES_KEY = rnd128();
        AES_MSG_PLAIN = rnd128();
      end
    end
    check("hold_done", 128'(hi), 128'd30);
    check("hold_enc", AES_MSG_ENC, ct);
    release_start("hold");
    run_vec("rerun", rnd128(), rnd128());
    release_start("rerun");

    // Asynchronous reset during round 5.
    start_enc(rnd128(), rnd128());
    repeat (4) @(posedge CLK);
    #2;
    RESET = 1'b0;
    AES_START = 1'b0;
    #1;
    check("abort_done", 128'(AES_DONE), 128'd0);
    check("abort_enc", AES_MSG_ENC, 128'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (AES_DONE) hi++;
    end
    check("abort_idle", 128'(hi) | (AES_MSG_ENC != 0 ? 128'd1 : 128'd0),
          128'd0);
    run_vec("post_rst", rnd128(), rnd128());
    release_start("post_rst");

    // Inputs change after sampling; start drops at round 3.
    k = rnd128();
    p = rnd128();
    start_enc(k, p);
    AES_KEY = rnd128();
    AES_MSG_PLAIN = rnd128();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    AES_START = 1'b0;
    wait_done(lat);
    check("early_lat", 128'(lat), 128'd8);
    check("early_ct", AES_MSG_ENC, ref_enc(k, p));
    @(posedge CLK); #1;
    check("early_pulse", 128'(AES_DONE), 128'd0);
    AES_KEY = rnd128();
    @(posedge CLK); #1;
    check("early_hold", AES_MSG_ENC, ref_enc(k, p));

    for (int n = 0; n < 200; n++) begin
      k = rnd128();
      p = rnd128();
      run_vec($sformatf("rnd%0d", n), k, p);
      check($sformatf("rt%0d", n), ref_dec(k, AES_MSG_ENC), p);
      AES_START = 1'b0;
      @(posedge CLK); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
